// File: rtl/effect_compressor_env_if.sv
// Sample-strobe bus for the envelope compressor stage: per-sample controls
// and data in, processed sample and gain-reduction meter out.
interface effect_compressor_env_if #(
    parameter int DATA_W   = 16,
    parameter int SHIFT_W  = 4,
    parameter int MAKEUP_W = 3
);
    // Strobe semantics: there is no ready. A sample is accepted on every rising
    // clock edge where i_valid is 1, and all i_* fields are captured with it.
    // o_valid is a one-cycle strobe per sample; o_data/o_gain_red hold between strobes.
    logic                 i_valid;
    logic                 i_enable;
    logic [DATA_W-2:0]    i_threshold;
    logic [SHIFT_W-1:0]   i_ratio_shift;
    logic [SHIFT_W-1:0]   i_attack_shift;
    logic [SHIFT_W-1:0]   i_release_shift;
    logic [MAKEUP_W-1:0]  i_makeup_shift;
    logic [DATA_W-1:0]    i_data;
    logic [DATA_W-1:0]    o_data;
    logic                 o_valid;
    logic [DATA_W-2:0]    o_gain_red;

    modport master (
        output i_valid, i_enable, i_threshold, i_ratio_shift, i_attack_shift,
               i_release_shift, i_makeup_shift, i_data,
        input  o_data, o_valid, o_gain_red
    );

    modport slave (
        input  i_valid, i_enable, i_threshold, i_ratio_shift, i_attack_shift,
               i_release_shift, i_makeup_shift, i_data,
        output o_data, o_valid, o_gain_red
    );
endinterface

// File: rtl/effect_compressor_env.sv
// Envelope-driven compressor: peak envelope with attack/release, power-of-two
// ratio above a threshold, saturating makeup gain. Two-clock latency, bypass aligned.
module effect_compressor_env #(
    parameter int DATA_W   = 16,
    parameter int SHIFT_W  = 4,
    parameter int MAKEUP_W = 3
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    effect_compressor_env_if.slave  bus
);
    localparam int MAG_W  = DATA_W - 1;
    localparam int WIDE_W = MAG_W + (1 << MAKEUP_W) - 1;
    localparam logic [MAG_W-1:0]  MAX      = {MAG_W{1'b1}};
    localparam logic [WIDE_W-1:0] MAX_WIDE = {{(WIDE_W-MAG_W){1'b0}}, MAX};

    // Stage 1 registers
    logic                 s1_valid;
    logic                 s1_sign;
    logic [MAG_W-1:0]     s1_abs;
    logic                 s1_enable;
    logic [MAG_W-1:0]     s1_thr;
    logic [SHIFT_W-1:0]   s1_ratio;
    logic [MAKEUP_W-1:0]  s1_makeup;
    logic [DATA_W-1:0]    s1_raw;
    logic [MAG_W-1:0]     env;

    // Output registers
    logic                 o_valid_q;
    logic [DATA_W-1:0]    o_data_q;
    logic [MAG_W-1:0]     o_gr_q;

    // Stage 1 combinational
    logic [DATA_W-1:0]    neg_data;
    logic [MAG_W-1:0]     in_abs;
    logic [MAG_W-1:0]     env_next;

    always_comb begin
        neg_data = ~bus.i_data + DATA_W'(1);
        if (bus.i_data[DATA_W-1]) begin
            // Only the most-negative input still has its MSB set after negation.
            in_abs = neg_data[DATA_W-1] ? MAX : neg_data[MAG_W-1:0];
        end else begin
            in_abs = bus.i_data[MAG_W-1:0];
        end
    end

    always_comb begin
        env_next = env;
        if (in_abs > env) begin
            env_next = env + ((in_abs - env) >> bus.i_attack_shift);
        end else begin
            env_next = env - ((env - in_abs) >> bus.i_release_shift);
        end
    end

    // Stage 2 combinational, working on the envelope already updated by this sample
    logic [MAG_W-1:0]     over;
    logic [MAG_W-1:0]     gr;
    logic [MAG_W-1:0]     mag;
    logic [WIDE_W-1:0]    wide;
    logic [MAG_W-1:0]     sat;
    logic [DATA_W-1:0]    mag_out;
    logic [DATA_W-1:0]    comp_data;

    always_comb begin
        over = '0;
        if (env > s1_thr) begin
            over = env - s1_thr;
        end
        gr = over - (over >> s1_ratio);
        // During a release tail the reduction can exceed the current sample.
        mag = (gr > s1_abs) ? '0 : (s1_abs - gr);
        wide = {{(WIDE_W-MAG_W){1'b0}}, mag} << s1_makeup;
        sat = (wide > MAX_WIDE) ? MAX : wide[MAG_W-1:0];
        mag_out = {1'b0, sat};
        comp_data = s1_sign ? (~mag_out + DATA_W'(1)) : mag_out;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_abs    <= '0;
            s1_enable <= 1'b0;
            s1_thr    <= '0;
            s1_ratio  <= '0;
            s1_makeup <= '0;
            s1_raw    <= '0;
            env       <= '0;
        end else begin
            s1_valid <= bus.i_valid;
            if (bus.i_valid) begin
                s1_sign   <= bus.i_data[DATA_W-1];
                s1_abs    <= in_abs;
                s1_enable <= bus.i_enable;
                s1_thr    <= bus.i_threshold;
                s1_ratio  <= bus.i_ratio_shift;
                s1_makeup <= bus.i_makeup_shift;
                s1_raw    <= bus.i_data;
                env       <= env_next;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_gr_q    <= '0;
        end else begin
            o_valid_q <= s1_valid;
            if (s1_valid) begin
                o_data_q <= s1_enable ? comp_data : s1_raw;
                o_gr_q   <= s1_enable ? gr : '0;
            end
        end
    end

    assign bus.o_valid    = o_valid_q;
    assign bus.o_data     = o_data_q;
    assign bus.o_gain_red = o_gr_q;

endmodule
